opcode_fetch: RTL and testbench
===============================

Name: opcode_fetch

Overview:
- Instruction-byte fetch sequencer for the 6809/6309-compatible core.
- Reads opcode bytes from the memory bus starting at a loaded PC.
- Recognises the page-2 (0x10) and page-3 (0x11) prefixes and fetches postbyte0 where needed.
- Presents opcode, postbyte0, page2_valid and page3_valid to the decode/sequencer stage over a valid/ready handshake. It is the producer of the signals the decoders consume.

Parameters:
- PAGE2_PREFIX, 8'h10, prefix byte selecting page 2.
- PAGE3_PREFIX, 8'h11, prefix byte selecting page 3.
- MAX_PREFIX, 3, maximum consecutive prefix bytes accepted before the instruction is flagged illegal.

Ports:
- cpu_clk  in  1  core clock, all state on rising edge.
- cpu_reset_n  in  1  asynchronous active-low reset.
- pc_load  in  1  load new fetch PC (branch/vector/flush).
- pc_i  in  16  new fetch PC, valid with pc_load.
- bus_addr_o  out  16  fetch address.
- bus_rd_o  out  1  read request.
- bus_data_i  in  8  read data, valid when bus_ack_i=1.
- bus_ack_i  in  1  read completes this cycle.
- inst_valid_o  out  1  instruction bundle valid.
- inst_ready_i  in  1  consumer accepts bundle.
- opcode_o  out  8  page-1 opcode, or the prefix byte for page 2/3.
- postbyte0_o  out  8  page-2/3 opcode, or TFR/EXG/PSH/PUL register postbyte.
- page2_valid_o  out  1  postbyte0_o holds a loaded page-2 opcode.
- page3_valid_o  out  1  postbyte0_o holds a loaded page-3 opcode.
- inst_pc_o  out  16  address of the instruction's first byte.
- pc_next_o  out  16  address after the last byte consumed.
- illegal_o  out  1  prefix count exceeded MAX_PREFIX.

Behaviour:
- Reset: state WAIT_PC. bus_rd_o=0, bus_addr_o=0, inst_valid_o=0, opcode_o=0, postbyte0_o=0, page2/3_valid_o=0, inst_pc_o=0, pc_next_o=0, illegal_o=0, prefix count=0.
- States:
  - WAIT_PC: idle until pc_load.
  - FETCH_OP: bus_rd_o=1, bus_addr_o=fetch PC.
  - FETCH_PB: fetches postbyte0.
  - PRESENT: bundle valid, waiting for the consumer.
- WAIT_PC -> FETCH_OP on pc_load. fetch PC=pc_i; inst_pc latched=pc_i.
- FETCH_OP, on ack:
  - Byte is a prefix: opcode_o=byte, record page (a later prefix overrides an earlier one), increment prefix count, PC+1, go to FETCH_PB.
  - Byte is 0x1E, 0x1F or 0x34..0x37: opcode_o=byte, PC+1, go to FETCH_PB.
  - Otherwise: opcode_o=byte, PC+1, go to PRESENT.
- FETCH_PB, on ack:
  - Byte is a prefix while a page is recorded: treated as a new prefix, same rules, stay in FETCH_PB.
  - Prefix count would exceed MAX_PREFIX: illegal_o=1, go to PRESENT.
  - Otherwise: postbyte0_o=byte, set page2/3_valid_o per the recorded page, PC+1, go to PRESENT.
- PRESENT:
  - inst_valid_o=1. pc_next_o=fetch PC.
  - Every bundle output is stable while inst_ready_i=0.
  - On inst_valid_o & inst_ready_i: clear valid, page flags, illegal_o and prefix count; inst_pc=pc_next; go to FETCH_OP next cycle.
- Bus rules:
  - bus_addr_o stays stable while bus_rd_o=1 and no ack.
  - Data is sampled only in the ack cycle.
  - Ack outside FETCH_OP/FETCH_PB is ignored.
- pc_load has priority in every state, including over an ack in the same cycle; that ack's data is discarded. pc_load aborts the outstanding read, clears the bundle and flags, loads pc_i, and enters FETCH_OP next cycle.
- PC arithmetic is 16-bit and wraps: 16'hFFFF+1=16'h0000. Multi-byte instructions may straddle the wrap.
- Latency with zero-wait memory (ack in the same cycle as rd):
  - pc_load in cycle 0 -> rd in cycle 1 -> inst_valid_o in cycle 2 for a 1-byte opcode.
  - Add one cycle per additional byte.
- Async reset mid-read: bus_rd_o drops immediately; no partial bundle is ever presented.

Optional Feature:
- Macro OPCODE_FETCH_PREFETCH_EN.
- Defined:
  - In PRESENT, the block issues a read at pc_next_o into a 1-byte prefetch buffer with a valid bit.
  - On accept with the buffer valid: the buffered byte is processed as the FETCH_OP ack in the accept cycle, saving one cycle.
  - pc_load or reset invalidates the buffer; a fill in progress is abandoned.
- Undefined: no buffer; bus_rd_o=0 in PRESENT.

Decomposition:
- Shared defs include: state encodings (FS_WAIT_PC, FS_FETCH_OP, FS_FETCH_PB, FS_PRESENT), prefix constants, page encodings.
- Sub-module fetch_classify (combinational): byte -> is_prefix, needs_postbyte, page. Reusable by the decoders.

Test Plan:
- pc_load pc_i=16'h1000, memory[1000]=8'h86, ack every cycle -> inst_valid_o in cycle 2, opcode_o=8'h86, page flags 0, inst_pc_o=16'h1000, pc_next_o=16'h1001.
- memory 10 8E at 16'h2000 -> opcode_o=8'h10, postbyte0_o=8'h8E, page2_valid_o=1, page3_valid_o=0, pc_next_o=16'h2002.
- memory 1F 89 at 16'hFFFF -> postbyte0_o=8'h89, page2/3_valid_o=0, pc_next_o=16'h0001.
- bytes 10 11 10 11 -> illegal_o=1 with inst_valid_o; bytes 10 11 83 -> page3_valid_o=1, postbyte0_o=8'h83.
- inst_ready_i held 0 for 5 cycles -> all bundle outputs constant; pc_load=1 with bus_ack_i=1 in the same cycle -> ack data discarded, next bus_addr_o=pc_i.
- With OPCODE_FETCH_PREFETCH_EN: back-to-back 1-byte opcodes at 16'h3000/16'h3001, ready=1 -> bundles on consecutive presentation with no FETCH_OP cycle; a pc_load during the fill -> buffered byte never presented.

Source files
------------

// File: rtl/opcode_fetch_pkg.sv
// Shared definitions for the opcode fetch sequencer and its byte classifier.
package opcode_fetch_pkg;

    localparam logic [7:0] DEF_PAGE2_PREFIX = 8'h10;
    localparam logic [7:0] DEF_PAGE3_PREFIX = 8'h11;
    localparam logic [2:0] DEF_MAX_PREFIX   = 3'd3;

    typedef enum logic [1:0] {
        FS_WAIT_PC  = 2'd0,
        FS_FETCH_OP = 2'd1,
        FS_FETCH_PB = 2'd2,
        FS_PRESENT  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PAGE_NONE = 2'd0,
        PAGE_2    = 2'd1,
        PAGE_3    = 2'd2
    } page_e;

endpackage

// File: rtl/fetch_classify.sv
// Combinational opcode-byte classifier: prefix detection, postbyte need, page select.
// Zero latency; no flow control.
module fetch_classify
    import opcode_fetch_pkg::*;
#(
    parameter logic [7:0] PAGE2_PREFIX = DEF_PAGE2_PREFIX,
    parameter logic [7:0] PAGE3_PREFIX = DEF_PAGE3_PREFIX
) (
    input  logic [7:0] byte_i,
    output logic       is_prefix_o,
    output logic       needs_postbyte_o,
    output logic [1:0] page_o
);

    always_comb begin
        is_prefix_o = (byte_i == PAGE2_PREFIX) || (byte_i == PAGE3_PREFIX);
        if (byte_i == PAGE2_PREFIX)
            page_o = PAGE_2;
        else if (byte_i == PAGE3_PREFIX)
            page_o = PAGE_3;
        else
            page_o = PAGE_NONE;
        // EXG/TFR (1E/1F) and PSHS/PULS/PSHU/PULU (34..37) carry a register postbyte
        needs_postbyte_o = is_prefix_o || (byte_i == 8'h1E) || (byte_i == 8'h1F)
                           || (byte_i[7:2] == 6'b001101);
    end

endmodule

// File: rtl/opcode_fetch.sv
// Opcode/prefix/postbyte0 fetch sequencer feeding decode; optional 1-byte prefetch (OPCODE_FETCH_PREFETCH_EN).
// Latency: pc_load -> bundle valid 2 cycles for a 1-byte opcode with zero-wait memory, +1 per extra byte.
// Backpressure: bundle held stable in PRESENT until inst_ready_i; pc_load preempts everything.
module opcode_fetch
    import opcode_fetch_pkg::*;
#(
    parameter logic [7:0] PAGE2_PREFIX = DEF_PAGE2_PREFIX,
    parameter logic [7:0] PAGE3_PREFIX = DEF_PAGE3_PREFIX,
    parameter logic [2:0] MAX_PREFIX   = DEF_MAX_PREFIX
) (
    input  logic        cpu_clk,
    input  logic        cpu_reset_n,
    input  logic        pc_load,
    input  logic [15:0] pc_i,
    output logic [15:0] bus_addr_o,
    output logic        bus_rd_o,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_ack_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [7:0]  opcode_o,
    output logic [7:0]  postbyte0_o,
    output logic        page2_valid_o,
    output logic        page3_valid_o,
    output logic [15:0] inst_pc_o,
    output logic [15:0] pc_next_o,
    output logic        illegal_o
);

    fetch_state_e state_q, state_d;
    page_e        page_q, page_d;
    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic [15:0]  inst_pc_q, inst_pc_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [7:0]   postbyte_q, postbyte_d;
    logic [2:0]   pfx_cnt_q, pfx_cnt_d;
    logic         p2v_q, p2v_d, p3v_q, p3v_d, illegal_q, illegal_d;

    logic         pf_rd, pf_hit, op_take;
    logic [7:0]   pf_byte, cls_byte;
    logic         cls_prefix, cls_needs_pb;
    logic [1:0]   cls_page;
    logic [2:0]   pfx_inc;

`ifdef OPCODE_FETCH_PREFETCH_EN
    logic         pf_vld_q;
    logic [7:0]   pf_byte_q;

    assign pf_rd   = (state_q == FS_PRESENT) && !pf_vld_q;
    // A fill acked in the accept cycle is used directly rather than forcing a refetch
    assign pf_hit  = pf_vld_q || (pf_rd && bus_ack_i);
    assign pf_byte = pf_vld_q ? pf_byte_q : bus_data_i;

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            pf_vld_q  <= 1'b0;
            pf_byte_q <= 8'h00;
        end else if (pc_load || (state_q == FS_PRESENT && inst_ready_i)) begin
            pf_vld_q  <= 1'b0;
        end else if (pf_rd && bus_ack_i) begin
            pf_vld_q  <= 1'b1;
            pf_byte_q <= bus_data_i;
        end
    end
`else
    assign pf_rd   = 1'b0;
    assign pf_hit  = 1'b0;
    assign pf_byte = bus_data_i;
`endif

    assign cls_byte = (state_q == FS_PRESENT) ? pf_byte : bus_data_i;
    assign pfx_inc  = pfx_cnt_q + 3'd1;

    fetch_classify #(
        .PAGE2_PREFIX (PAGE2_PREFIX),
        .PAGE3_PREFIX (PAGE3_PREFIX)
    ) u_classify (
        .byte_i           (cls_byte),
        .is_prefix_o      (cls_prefix),
        .needs_postbyte_o (cls_needs_pb),
        .page_o           (cls_page)
    );

    assign op_take = !pc_load &&
                     (((state_q == FS_FETCH_OP) && bus_ack_i) ||
                      ((state_q == FS_PRESENT) && inst_ready_i && pf_hit));

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        fetch_pc_d = fetch_pc_q;
        inst_pc_d  = inst_pc_q;
        opcode_d   = opcode_q;
        postbyte_d = postbyte_q;
        pfx_cnt_d  = pfx_cnt_q;
        p2v_d      = p2v_q;
        p3v_d      = p3v_q;
        illegal_d  = illegal_q;

        if (pc_load) begin
            state_d    = FS_FETCH_OP;
            fetch_pc_d = pc_i;
            inst_pc_d  = pc_i;
            opcode_d   = 8'h00;
            postbyte_d = 8'h00;
            page_d     = PAGE_NONE;
            pfx_cnt_d  = 3'd0;
            p2v_d      = 1'b0;
            p3v_d      = 1'b0;
            illegal_d  = 1'b0;
        end else begin
            if (state_q == FS_FETCH_PB && bus_ack_i) begin
                if (cls_prefix && page_q != PAGE_NONE) begin
                    if (pfx_inc > MAX_PREFIX) begin
                        illegal_d = 1'b1;
                        state_d   = FS_PRESENT;
                    end else begin
                        opcode_d   = bus_data_i;
                        page_d     = page_e'(cls_page);
                        pfx_cnt_d  = pfx_inc;
                        fetch_pc_d = fetch_pc_q + 16'd1;
                    end
                end else begin
                    postbyte_d = bus_data_i;
                    p2v_d      = (page_q == PAGE_2);
                    p3v_d      = (page_q == PAGE_3);
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    state_d    = FS_PRESENT;
                end
            end

            if (state_q == FS_PRESENT && inst_ready_i) begin
                state_d   = FS_FETCH_OP;
                inst_pc_d = fetch_pc_q;
                page_d    = PAGE_NONE;
                pfx_cnt_d = 3'd0;
                p2v_d     = 1'b0;
                p3v_d     = 1'b0;
                illegal_d = 1'b0;
            end

            // First byte of an instruction, from the bus or from the prefetch buffer
            if (op_take) begin
                opcode_d   = cls_byte;
                fetch_pc_d = fetch_pc_q + 16'd1;
                page_d     = page_e'(cls_page);
                pfx_cnt_d  = cls_prefix ? 3'd1 : 3'd0;
                state_d    = cls_needs_pb ? FS_FETCH_PB : FS_PRESENT;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q    <= FS_WAIT_PC;
            page_q     <= PAGE_NONE;
            fetch_pc_q <= 16'h0000;
            inst_pc_q  <= 16'h0000;
            opcode_q   <= 8'h00;
            postbyte_q <= 8'h00;
            pfx_cnt_q  <= 3'd0;
            p2v_q      <= 1'b0;
            p3v_q      <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            fetch_pc_q <= fetch_pc_d;
            inst_pc_q  <= inst_pc_d;
            opcode_q   <= opcode_d;
            postbyte_q <= postbyte_d;
            pfx_cnt_q  <= pfx_cnt_d;
            p2v_q      <= p2v_d;
            p3v_q      <= p3v_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus_rd_o      = (state_q == FS_FETCH_OP) || (state_q == FS_FETCH_PB) || pf_rd;
    assign bus_addr_o    = fetch_pc_q;
    assign inst_valid_o  = (state_q == FS_PRESENT);
    assign opcode_o      = opcode_q;
    assign postbyte0_o   = postbyte_q;
    assign page2_valid_o = p2v_q;
    assign page3_valid_o = p3v_q;
    assign inst_pc_o     = inst_pc_q;
    assign pc_next_o     = fetch_pc_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// Bench for opcode_fetch: directed vector table, corner sequences, and a randomized
// run scored against an instruction-parsing reference model over a memory image.
module tb_opcode_fetch;

    logic        cpu_clk = 1'b0;
    logic        cpu_reset_n = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_i = 16'h0000;
    logic [15:0] bus_addr_o;
    logic        bus_rd_o;
    logic [7:0]  bus_data_i = 8'h00;
    logic        bus_ack_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [7:0]  opcode_o, postbyte0_o;
    logic        page2_valid_o, page3_valid_o, illegal_o;
    logic [15:0] inst_pc_o, pc_next_o;

    opcode_fetch dut (
        .cpu_clk       (cpu_clk),
        .cpu_reset_n   (cpu_reset_n),
        .pc_load       (pc_load),
        .pc_i          (pc_i),
        .bus_addr_o    (bus_addr_o),
        .bus_rd_o      (bus_rd_o),
        .bus_data_i    (bus_data_i),
        .bus_ack_i     (bus_ack_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .opcode_o      (opcode_o),
        .postbyte0_o   (postbyte0_o),
        .page2_valid_o (page2_valid_o),
        .page3_valid_o (page3_valid_o),
        .inst_pc_o     (inst_pc_o),
        .pc_next_o     (pc_next_o),
        .illegal_o     (illegal_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    logic [7:0] mem [65536];
    int ack_mode = 1;   // 0: never ack, 1: ack every read, 2: random wait states
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  pb;
        logic        has_pb;
        logic        p2;
        logic        p3;
        logic        ill;
        logic [15:0] nxt;
    } bundle_t;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] bytes;
        int          nbytes;
        logic [7:0]  op;
        logic [7:0]  pb;
        logic        chk_pb;
        logic        p2;
        logic        p3;
        logic        ill;
        logic [15:0] nxt;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the byte stream by the instruction-format rules
    function automatic bundle_t parse(input logic [15:0] start);
        bundle_t    r;
        logic [15:0] p;
        logic [7:0]  b, page;
        int          cnt;
        logic        done;
        r = '{op: 8'h00, pb: 8'h00, has_pb: 1'b0, p2: 1'b0, p3: 1'b0, ill: 1'b0, nxt: 16'h0000};
        p = start;
        b = mem[p];
        p = p + 16'd1;
        r.op = b;
        if (b == 8'h10 || b == 8'h11) begin
            page = b;
            cnt  = 1;
            done = 1'b0;
            while (!done) begin
                b = mem[p];
                if (b == 8'h10 || b == 8'h11) begin
                    if (cnt + 1 > 3) begin
                        r.ill = 1'b1;
                        done  = 1'b1;
                    end else begin
                        cnt++;
                        page = b;
                        r.op = b;
                        p    = p + 16'd1;
                    end
                end else begin
                    r.pb     = b;
                    r.has_pb = 1'b1;
                    r.p2     = (page == 8'h10);
                    r.p3     = (page == 8'h11);
                    p        = p + 16'd1;
                    done     = 1'b1;
                end
            end
        end else if (b == 8'h1E || b == 8'h1F || (b >= 8'h34 && b <= 8'h37)) begin
            r.pb     = mem[p];
            r.has_pb = 1'b1;
            p        = p + 16'd1;
        end
        r.nxt = p;
        return r;
    endfunction

    task automatic chk_bundle(input string tag, input bundle_t e, input logic [15:0] ipc);
        chk({tag, ".op"}, opcode_o, e.op);
        if (e.has_pb && !e.ill) chk({tag, ".pb"}, postbyte0_o, e.pb);
        chk({tag, ".p2"}, page2_valid_o, e.p2);
        chk({tag, ".p3"}, page3_valid_o, e.p3);
        chk({tag, ".ill"}, illegal_o, e.ill);
        chk({tag, ".inst_pc"}, inst_pc_o, ipc);
        chk({tag, ".pc_next"}, pc_next_o, e.nxt);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge cpu_clk);
            pc_load = 1'b0;
            n++;
            if (inst_valid_o) break;
        end
        if (!inst_valid_o) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout: no inst_valid_o within %0d cycles", tag, budget);
        end
    endtask

    // Memory responder: acks are decided each cycle from the DUT's registered request
    initial begin
        forever begin
            @(negedge cpu_clk);
            if (bus_rd_o && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 2) != 0))) begin
                bus_ack_i  = 1'b1;
                bus_data_i = mem[bus_addr_o];
            end else begin
                bus_ack_i  = 1'b0;
                bus_data_i = 8'($urandom);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    vt[7];
        bundle_t e;
        int      n;
        logic [15:0] a, exp_pc;
        logic    seen;
        int      idle;

        vt[0] = '{16'h1000, 32'h86000000, 1, 8'h86, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1001, 2};
        vt[1] = '{16'h2000, 32'h108E0000, 2, 8'h10, 8'h8E, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2002, 3};
        vt[2] = '{16'hFFFF, 32'h1F890000, 2, 8'h1F, 8'h89, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 3};
        vt[3] = '{16'h4000, 32'h10111011, 4, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4003, 5};
        vt[4] = '{16'h5000, 32'h10118300, 3, 8'h11, 8'h83, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5003, 4};
        vt[5] = '{16'h6000, 32'h34100000, 2, 8'h34, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h6002, 3};
        vt[6] = '{16'h7000, 32'h114F0000, 2, 8'h11, 8'h4F, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7002, 3};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h4004] = 8'h12;

        // Reset state
        repeat (2) @(negedge cpu_clk);
        chk("rst.rd", bus_rd_o, 1'b0);
        chk("rst.addr", bus_addr_o, 16'h0000);
        chk("rst.valid", inst_valid_o, 1'b0);
        chk("rst.op", opcode_o, 8'h00);
        chk("rst.pb", postbyte0_o, 8'h00);
        chk("rst.p2", page2_valid_o, 1'b0);
        chk("rst.p3", page3_valid_o, 1'b0);
        chk("rst.inst_pc", inst_pc_o, 16'h0000);
        chk("rst.pc_next", pc_next_o, 16'h0000);
        chk("rst.ill", illegal_o, 1'b0);
        cpu_reset_n = 1'b1;
        repeat (2) @(negedge cpu_clk);
        chk("idle.rd", bus_rd_o, 1'b0);
        chk("idle.valid", inst_valid_o, 1'b0);

        // Directed vectors, zero-wait memory, with a 5-cycle stall on each bundle
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vt[v].nbytes; i++) begin
                a = vt[v].pc + 16'(i);
                mem[a] = vt[v].bytes[31 - 8*i -: 8];
            end
            pc_load = 1'b1;
            pc_i    = vt[v].pc;
            @(negedge cpu_clk);
            pc_load = 1'b0;
            chk("vec.fetch_rd", bus_rd_o, 1'b1);
            chk("vec.fetch_addr", bus_addr_o, vt[v].pc);
            n = 1;
            if (!inst_valid_o) begin
                wait_valid("vec", 20, idle);
                n = n + idle;
            end
            chk("vec.latency", n, vt[v].lat);
            for (int s = 0; s < 6; s++) begin
                chk("vec.valid", inst_valid_o, 1'b1);
                chk("vec.op", opcode_o, vt[v].op);
                if (vt[v].chk_pb) chk("vec.pb", postbyte0_o, vt[v].pb);
                chk("vec.p2", page2_valid_o, vt[v].p2);
                chk("vec.p3", page3_valid_o, vt[v].p3);
                chk("vec.ill", illegal_o, vt[v].ill);
                chk("vec.inst_pc", inst_pc_o, vt[v].pc);
                chk("vec.pc_next", pc_next_o, vt[v].nxt);
                if (s < 5) @(negedge cpu_clk);
            end
            inst_ready_i = 1'b1;
            @(negedge cpu_clk);
            inst_ready_i = 1'b0;
            chk("vec.accept_valid", inst_valid_o, 1'b0);
            chk("vec.accept_inst_pc", inst_pc_o, vt[v].nxt);
            chk("vec.accept_ill", illegal_o, 1'b0);
        end

        // pc_load coincident with an ack: the acked byte must be dropped
        mem[16'h8000] = 8'h39;
        pc_load = 1'b1;
        pc_i    = 16'h1000;
        @(negedge cpu_clk);
        pc_load = 1'b1;
        pc_i    = 16'h8000;
        chk("race.ack_seen", bus_ack_i, 1'b1);
        @(negedge cpu_clk);
        pc_load = 1'b0;
        chk("race.addr", bus_addr_o, 16'h8000);
        chk("race.rd", bus_rd_o, 1'b1);
        chk("race.valid", inst_valid_o, 1'b0);
        @(negedge cpu_clk);
        chk("race.valid2", inst_valid_o, 1'b1);
        chk("race.op", opcode_o, 8'h39);
        chk("race.inst_pc", inst_pc_o, 16'h8000);
        chk("race.pc_next", pc_next_o, 16'h8001);

        // Async reset while a read is outstanding
        ack_mode = 0;
        pc_load  = 1'b1;
        pc_i     = 16'h1000;
        @(negedge cpu_clk);
        pc_load = 1'b0;
        chk("arst.rd_pending", bus_rd_o, 1'b1);
        @(negedge cpu_clk);
        #2 cpu_reset_n = 1'b0;
        #1;
        chk("arst.rd_drop", bus_rd_o, 1'b0);
        chk("arst.addr", bus_addr_o, 16'h0000);
        @(negedge cpu_clk);
        ack_mode    = 1;
        cpu_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge cpu_clk);
            chk("arst.no_bundle", inst_valid_o, 1'b0);
            chk("arst.idle_rd", bus_rd_o, 1'b0);
        end

`ifdef OPCODE_FETCH_PREFETCH_EN
        mem[16'h3000] = 8'h86;
        mem[16'h3001] = 8'h4F;
        mem[16'h3002] = 8'h12;
        mem[16'h3003] = 8'hAA;
        mem[16'h3100] = 8'h5A;
        inst_ready_i  = 1'b1;
        pc_load       = 1'b1;
        pc_i          = 16'h3000;
        @(negedge cpu_clk);
        pc_load = 1'b0;
        @(negedge cpu_clk);
        chk("pf.valid0", inst_valid_o, 1'b1);
        chk("pf.op0", opcode_o, 8'h86);
        @(negedge cpu_clk);
        chk("pf.valid1", inst_valid_o, 1'b1);
        chk("pf.op1", opcode_o, 8'h4F);
        chk("pf.inst_pc1", inst_pc_o, 16'h3001);
        @(negedge cpu_clk);
        inst_ready_i = 1'b0;
        chk("pf.op2", opcode_o, 8'h12);
        @(negedge cpu_clk);
        chk("pf.hold_op", opcode_o, 8'h12);
        pc_load = 1'b1;
        pc_i    = 16'h3100;
        wait_valid("pf", 10, n);
        chk("pf.flush_op", opcode_o, 8'h5A);
        chk("pf.flush_inst_pc", inst_pc_o, 16'h3100);
        inst_ready_i = 1'b1;
        @(negedge cpu_clk);
        inst_ready_i = 1'b0;
`endif

        // Randomized run against the reference model
        for (int i = 0; i < 65536; i++) begin
            n = $urandom_range(0, 99);
            if (n < 20)      mem[i] = 8'h10;
            else if (n < 40) mem[i] = 8'h11;
            else if (n < 50) begin
                n = $urandom_range(0, 5);
                mem[i] = (n == 0) ? 8'h1E : (n == 1) ? 8'h1F : 8'(8'h32 + n);
            end else         mem[i] = 8'($urandom);
        end
        ack_mode     = 2;
        inst_ready_i = 1'b0;
        pc_load      = 1'b1;
        pc_i         = 16'($urandom);
        exp_pc       = pc_i;
        seen         = 1'b0;
        idle         = 0;
        e = parse(exp_pc);
        for (int c = 0; c < 4000; c++) begin
            @(negedge cpu_clk);
            if (inst_valid_o) begin
                idle = 0;
                if (!seen) begin
                    e = parse(exp_pc);
                    chk_bundle("rnd", e, exp_pc);
                    seen = 1'b1;
                end else begin
                    chk("rnd.hold_op", opcode_o, e.op);
                    chk("rnd.hold_pc_next", pc_next_o, e.nxt);
                end
            end else begin
                idle++;
                if (idle > 60) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd.liveness: no bundle for %0d cycles, want under 61", idle);
                    idle = 0;
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                pc_load      = 1'b1;
                pc_i         = 16'($urandom);
                exp_pc       = pc_i;
                seen         = 1'b0;
                inst_ready_i = 1'b0;
            end else begin
                pc_load      = 1'b0;
                inst_ready_i = ($urandom_range(0, 2) != 0);
                if (inst_ready_i && inst_valid_o) begin
                    exp_pc = e.nxt;
                    seen   = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
